// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Single-outstanding AXI4-Lite master. A simple valid/ready command port
//   launches one read or write; the result comes back on a valid/ready
//   response port. Every transaction has a cycle budget; when it runs out
//   the bus handshakes are withdrawn and a 2'b11 response is returned.
//
// Ports
//   ACLK, ARESET                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_resp            read data (0 for writes/aborts), xRESP or 2'b11
//   AW*/W*/B*/AR*/R*              AXI4-Lite master channels
module axi_lite_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          aw_done, w_done;

  logic [TW-1:0] tcnt_nxt;
  logic          active, expire;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // The budget is judged on the value the counter is about to take, so the
  // abort lands on the same edge the counter reaches TIMEOUT.
  assign active   = (state != IDLE) && (state != RESP);
  assign tcnt_nxt = tcnt + TW'(1);
  assign expire   = (tcnt_nxt == TO_LIM);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID  && WREADY;
  assign b_hs  = BVALID  && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID  && RREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      tcnt      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
    end else if (active && expire) begin
      // Abort wins over any handshake completing on this same edge.
      tcnt      <= tcnt_nxt;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b11;
      rsp_valid <= 1'b1;
      state     <= RESP;
    end else begin
      if (active) tcnt <= tcnt_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            tcnt      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_ADDR;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state   <= RD_ADDR;
            end
          end else begin
            // Held low for one cycle after a response so commands never overlap.
            cmd_ready <= 1'b1;
          end
        end
        WR_ADDR: begin
          // AW and W complete independently; move on once both have.
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            BREADY <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
//   Randomized scoreboard bench. A registered AXI-lite slave model (READY one
//   cycle after VALID plus a configurable wait, response one cycle after the
//   address/data handshake) sits on the bus; expected responses are derived
//   from a flat reference memory and pushed on command accept, and a monitor
//   pops them when the response handshake happens.
module tb_axi_lite_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- slave model ----------------
  int  aw_wait = 0, w_wait = 0, ar_wait = 0;
  bit  ar_hang = 1'b0;
  int  n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_same = 0;
  int  aw_cnt, w_cnt, ar_cnt;
  logic          aw_got, w_got, b_pend, r_pend;
  logic [AW-1:0] sl_awaddr, b_addr, r_addr;
  logic [DW-1:0] sl_wdata;
  logic [DW-1:0] mem [16];

  wire s_aw_hs  = AWVALID && AWREADY;
  wire s_w_hs   = WVALID && WREADY;
  wire s_ar_hs  = ARVALID && ARREADY;
  wire s_aw_fin = aw_got || s_aw_hs;
  wire s_w_fin  = w_got || s_w_hs;

  always @(posedge ACLK) begin
    if (ARESET) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; b_addr <= '0; r_addr <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (s_aw_hs) begin
        AWREADY <= 1'b0; aw_got <= 1'b1; aw_cnt <= 0; sl_awaddr <= AWADDR; n_aw <= n_aw + 1;
      end else if (AWVALID && !AWREADY && !aw_got) begin
        if (aw_cnt >= aw_wait) AWREADY <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (s_w_hs) begin
        WREADY <= 1'b0; w_got <= 1'b1; w_cnt <= 0; sl_wdata <= WDATA; n_w <= n_w + 1;
      end else if (WVALID && !WREADY && !w_got) begin
        if (w_cnt >= w_wait) WREADY <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (s_aw_hs && s_w_hs) n_same <= n_same + 1;
      if (s_aw_fin && s_w_fin) begin
        mem[s_aw_hs ? AWADDR : sl_awaddr] <= s_w_hs ? WDATA : sl_wdata;
        b_addr <= s_aw_hs ? AWADDR : sl_awaddr;
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (b_pend) begin
        BVALID <= 1'b1; BRESP <= (b_addr == 4'hF) ? 2'b10 : 2'b00; b_pend <= 1'b0;
      end
      if (BVALID && BREADY) begin BVALID <= 1'b0; n_b <= n_b + 1; end

      if (s_ar_hs) begin
        ARREADY <= 1'b0; r_pend <= 1'b1; r_addr <= ARADDR; ar_cnt <= 0; n_ar <= n_ar + 1;
      end else if (ARVALID && !ARREADY && !ar_hang) begin
        if (ar_cnt >= ar_wait) ARREADY <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
      if (r_pend) begin
        RVALID <= 1'b1; RDATA <= mem[r_addr]; RRESP <= (r_addr == 4'hF) ? 2'b10 : 2'b00;
        r_pend <= 1'b0;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // rsp_ready: 0 = always ready, 1 = random, 2 = held low
  int rr_mode = 0;
  always @(posedge ACLK) begin
    #2;
    case (rr_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    int            acc;
    int            lat;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_mem [16];

  // ---------------- monitor ----------------
  bit            chk_en = 1'b0;
  bit            prev_rv = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_rdata;
  logic [1:0]    prev_resp;
  int            rise_cyc = 0;
  logic          p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  exp_t          e_m;

  always @(negedge ACLK) begin
    if (chk_en && !ARESET) begin
      if (rsp_valid && !prev_rv) begin
        rise_cyc = cyc;
        check("bus_idle_in_resp", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
      end
      if (rsp_valid) check("cmd_ready_in_resp", cmd_ready, 0);
      if (prev_stall) check("rsp_held", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, prev_resp, prev_rdata});
      if (!(rsp_valid && rsp_resp == 2'b11)) begin
        if (p_awv && !p_awr) check("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
        if (p_awv && p_awr)  check("aw_drop", AWVALID, 0);
        if (p_wv && !p_wr)   check("w_hold", {WVALID, WDATA}, {1'b1, p_wdata});
        if (p_wv && p_wr)    check("w_drop", WVALID, 0);
        if (p_arv && !p_arr) check("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
        if (p_arv && p_arr)  check("ar_drop", ARVALID, 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got resp %0h data %0h with nothing expected", rsp_resp, rsp_rdata);
        end else begin
          e_m = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e_m.rdata);
          check("rsp_resp", rsp_resp, e_m.resp);
          check("rsp_latency", rise_cyc - e_m.acc, e_m.lat);
        end
      end
    end
    prev_rv    = rsp_valid;
    prev_stall = rsp_valid && !rsp_ready;
    prev_rdata = rsp_rdata;
    prev_resp  = rsp_resp;
    p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
    p_wv  = WVALID;  p_wr  = WREADY;  p_wdata  = WDATA;
    p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int aww, int ww, int arw, bit hang);
    exp_t e;
    int   n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 300) begin @(negedge ACLK); n++; end
    if (!cmd_ready) begin fail("cmd_accept"); cmd_valid = 1'b0; return; end
    aw_wait = aww; w_wait = ww; ar_wait = arw; ar_hang = hang;
    e.acc = cyc + 1;
    if (wr) begin
      ref_mem[a] = d;
      e.rdata = '0;
      e.resp  = (a == 4'hF) ? 2'b10 : 2'b00;
      e.lat   = 4 + ((aww > ww) ? aww : ww);
    end else if (hang) begin
      e.rdata = '0; e.resp = 2'b11; e.lat = TO;
    end else begin
      e.rdata = ref_mem[a];
      e.resp  = (a == 4'hF) ? 2'b10 : 2'b00;
      e.lat   = 4 + arw;
    end
    sb.push_back(e);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 300) begin @(negedge ACLK); n++; end
    if (sb.size() != 0 || rsp_valid) fail("wait_idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_aw, s_w, s_b, s_same, s_ar, n;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // reset values
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    check("rst_rsp_data", {rsp_resp, rsp_rdata}, 0);
    check("rst_axi_data", {AWADDR, ARADDR, WDATA}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("cmd_ready_after_rst", cmd_ready, 1);
    chk_en = 1'b1;

    // zero-wait write: AW and W in one cycle, one B
    s_same = n_same; s_b = n_b;
    issue(1'b1, 4'h3, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    wait_idle();
    check("wr_same_cycle_hs", n_same - s_same, 1);
    check("wr_b_count", n_b - s_b, 1);

    // read it back
    issue(1'b0, 4'h3, '0, 0, 0, 0, 1'b0);
    wait_idle();

    // AWREADY two cycles ahead of WREADY
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_same = n_same;
    issue(1'b1, 4'h5, $urandom, 0, 2, 0, 1'b0);
    wait_idle();
    check("split_aw_count", n_aw - s_aw, 1);
    check("split_w_count", n_w - s_w, 1);
    check("split_b_count", n_b - s_b, 1);
    check("split_same_cycle", n_same - s_same, 0);

    // ARREADY never comes: abort at TIMEOUT
    s_ar = n_ar;
    issue(1'b0, 4'h7, '0, 0, 0, 0, 1'b1);
    wait_idle();
    check("timeout_no_ar_hs", n_ar - s_ar, 0);
    @(negedge ACLK);
    check("idle_after_timeout", cmd_ready, 1);

    // response stalled 5 cycles with another command pending
    rr_mode = 2;
    issue(1'b0, 4'h3, '0, 0, 0, 0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
    if (!rsp_valid) fail("stall_rsp");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h9; cmd_wdata = 32'h1234_5678;
    repeat (5) @(negedge ACLK);
    check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
    check("stall_cmd_ready", cmd_ready, 0);
    rr_mode = 0;
    issue(1'b1, 4'h9, 32'h1234_5678, 0, 0, 0, 1'b0);
    wait_idle();
    issue(1'b0, 4'h9, '0, 0, 0, 0, 1'b0);
    wait_idle();

    // reset while waiting for B
    issue(1'b1, 4'h2, 32'hCAFE_0002, 0, 0, 0, 1'b0);
    n = 0;
    while (!BREADY && n < 20) begin @(negedge ACLK); n++; end
    if (!BREADY) fail("reach_wr_resp");
    chk_en = 1'b0;
    s_b = n_b;
    ARESET = 1'b1;
    sb.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge ACLK);
    check("midrst_ctrl", {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_no_rsp", rsp_valid, 0);
    check("midrst_no_b", n_b - s_b, 0);
    chk_en = 1'b1;

    // randomized traffic with random response back-pressure
    rr_mode = 1;
    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    wait_idle();
    rr_mode = 0;
    repeat (3) @(negedge ACLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 4, giving the AXI address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles per transaction before abort; the counter width SHALL be $clog2(TIMEOUT+1).
REQ-004 The module SHALL have these ports:
  ACLK  in  1  the single clock; all logic is rising-edge.
  ARESET  in  1  synchronous, active-high reset.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  command accepted (IDLE only).
  cmd_write  in  1  1 = write, 0 = read.
  cmd_addr  in  ADDR_W  target address.
  cmd_wdata  in  DATA_W  write data.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  response consumed.
  rsp_rdata  out  DATA_W  read data (0 for writes/timeouts).
  rsp_resp  out  2  BRESP/RRESP copy; 2'b11 on timeout.
  AWADDR/AWVALID/AWREADY, WDATA/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  master side of AXI4-Lite; widths ADDR_W, DATA_W, and 2 for BRESP/RRESP.

Function
REQ-005 The module SHALL use the FSM states IDLE, WR_ADDR (AW/W phase), WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-006 All outputs SHALL be registered.
REQ-007 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1, latching addr, wdata and write.
REQ-008 On a write accept, the module SHALL enter WR_ADDR with AWVALID=1 and WVALID=1 asserted together on the next cycle, with AWADDR and WDATA driven from the latched values.
REQ-009 In WR_ADDR, the AW and W handshakes SHALL be tracked independently (aw_done, w_done).
REQ-010 Each VALID SHALL drop the cycle after its own READY is sampled high.
REQ-011 The module SHALL enter WR_RESP when both aw_done and w_done are set, whether the handshakes occur in the same cycle or different cycles.
REQ-012 In WR_RESP, BREADY SHALL be 1; on BVALID&&BREADY the module SHALL capture BRESP into rsp_resp, set rsp_rdata=0, set BREADY=0 and enter RESP.
REQ-013 On a read accept, the module SHALL enter RD_ADDR with ARVALID=1; on ARREADY it SHALL drop ARVALID and enter RD_DATA.
REQ-014 In RD_DATA, RREADY SHALL be 1; on RVALID&&RREADY the module SHALL capture RDATA and RRESP, set RREADY=0 and enter RESP.
REQ-015 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_resp SHALL be held stable until rsp_ready.
REQ-016 On the rsp handshake the module SHALL return to IDLE; cmd_ready SHALL rise on the following cycle (no back-to-back overlap).
REQ-017 AWADDR, WDATA and ARADDR SHALL stay stable while their VALID is high; a VALID SHALL never be withdrawn before its READY except on timeout.
REQ-018 The timeout counter SHALL clear on command accept and increment every cycle outside IDLE and RESP.
REQ-019 When the timeout counter equals TIMEOUT, the module SHALL deassert all VALID/READY outputs, set rsp_resp=2'b11 and rsp_rdata=0, and enter RESP.
REQ-020 Timeout SHALL take priority over a handshake completing in the same cycle.
REQ-021 Against a zero-wait slave whose READYs are registered, rsp_valid SHALL rise 4 cycles after the command-accept edge for both reads and writes.
REQ-022 Commands presented while not in IDLE SHALL be ignored and not dropped; they remain pending under cmd_valid.

Reset
REQ-023 While ARESET=1 at a rising edge, the state SHALL become IDLE and the timeout counter and aw_done/w_done SHALL clear.
REQ-024 While ARESET=1 at a rising edge, cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID and RREADY SHALL be 0.
REQ-025 While ARESET=1 at a rising edge, rsp_rdata, rsp_resp, AWADDR, WDATA and ARADDR SHALL be 0.
REQ-026 cmd_ready SHALL be 1 after the first edge with ARESET=0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no response issued.

Verification
REQ-028 The bench SHALL cover: write addr=4'h3, data=32'hDEADBEEF to the team's AXI-lite slave -> one AW/W handshake in the same cycle, BRESP=00, rsp_valid 4 cycles after accept, rsp_resp=00.
REQ-029 The bench SHALL cover: read addr=4'h3 after that write -> rsp_rdata=32'hDEADBEEF, rsp_resp=00, rsp_valid 4 cycles after accept.
REQ-030 The bench SHALL cover: a slave that gives AWREADY 2 cycles before WREADY -> AWVALID drops after its handshake, WVALID is held until WREADY, and exactly one B handshake occurs.
REQ-031 The bench SHALL cover: a slave that never asserts ARREADY, with TIMEOUT=8 -> ARVALID drops, rsp_resp=2'b11 and rsp_rdata=0 at cycle 8 after accept, then return to IDLE.
REQ-032 The bench SHALL cover: rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stay stable and cmd_ready stays 0 throughout.
REQ-033 The bench SHALL cover: ARESET pulsed while in WR_RESP -> all VALID/READY outputs are 0 on the next edge, and cmd_ready=1 the edge after reset releases.
